// File: rtl/source_frame_gen.sv
// Test-pattern frame generator: optional 2-word header, counted payload, idle gap,
// with run length, graceful stop, clear-abort and single-frame truncation.
module source_frame_gen (
  input  logic        clk,
  input  logic        pRST,
  input  logic [7:0]  source_channel,
  input  logic [15:0] source_framelen,
  input  logic [15:0] source_blanklen,
  input  logic        source_start_send,
  input  logic        source_stop_send,
  input  logic [31:0] source_totalnum,
  input  logic [31:0] source_cutnum,
  input  logic        source_headen,
  input  logic        source_clrfifo,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eof,
  output logic        busy,
  output logic        done,
  output logic [31:0] frames_sent,
  output logic        cfg_err
);

  localparam logic [15:0] HEAD_SYNC = 16'hEB90;

  typedef enum logic [2:0] {StIdle, StHead0, StHead1, StData, StGap} state_e;

  state_e      state_q, state_d;
  logic        start_prev_q, stop_prev_q;
  logic [7:0]  ch_q, ch_d;
  logic [15:0] framelen_q, framelen_d;
  logic [15:0] blanklen_q, blanklen_d;
  logic [31:0] totalnum_q, totalnum_d;
  logic [31:0] cutnum_q, cutnum_d;
  logic        headen_q, headen_d;
  logic [15:0] k_q, k_d;
  logic [15:0] gap_q, gap_d;
  logic [31:0] fs_q, fs_d;
  logic        stop_pend_q, stop_pend_d;
  logic        cfg_err_q, cfg_err_d;
  logic        done_q, done_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_sof_q, out_sof_d;
  logic        out_eof_q, out_eof_d;

  logic        start_edge, stop_edge, accept;
  state_e      first_state;
  logic [15:0] cur_len, next_len;

  // Truncated frame carries half the payload, but never less than one word.
  function automatic logic [15:0] frame_len(input logic [15:0] fl, input logic [31:0] cut,
                                            input logic [31:0] idx);
    logic [15:0] half;
    half = fl >> 1;
    if (cut != 32'd0 && idx == cut) return (half == 16'd0) ? 16'd1 : half;
    return fl;
  endfunction

  assign start_edge  = source_start_send & ~start_prev_q;
  assign stop_edge   = source_stop_send & ~stop_prev_q;
  assign accept      = out_valid_q & out_ready;
  assign first_state = headen_q ? StHead0 : StData;
  assign cur_len     = frame_len(framelen_q, cutnum_q, fs_q + 32'd1);

  always_ff @(posedge clk or posedge pRST) begin
    if (pRST) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      ch_q         <= '0;
      framelen_q   <= '0;
      blanklen_q   <= '0;
      totalnum_q   <= '0;
      cutnum_q     <= '0;
      headen_q     <= 1'b0;
      k_q          <= '0;
      gap_q        <= '0;
      fs_q         <= '0;
      stop_pend_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
      done_q       <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= source_start_send;
      stop_prev_q  <= source_stop_send;
      ch_q         <= ch_d;
      framelen_q   <= framelen_d;
      blanklen_q   <= blanklen_d;
      totalnum_q   <= totalnum_d;
      cutnum_q     <= cutnum_d;
      headen_q     <= headen_d;
      k_q          <= k_d;
      gap_q        <= gap_d;
      fs_q         <= fs_d;
      stop_pend_q  <= stop_pend_d;
      cfg_err_q    <= cfg_err_d;
      done_q       <= done_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_sof_q    <= out_sof_d;
      out_eof_q    <= out_eof_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    framelen_d  = framelen_q;
    blanklen_d  = blanklen_q;
    totalnum_d  = totalnum_q;
    cutnum_d    = cutnum_q;
    headen_d    = headen_q;
    k_d         = k_q;
    gap_d       = gap_q;
    fs_d        = fs_q;
    stop_pend_d = stop_pend_q;
    cfg_err_d   = cfg_err_q;
    done_d      = 1'b0;
    if (source_clrfifo) begin
      state_d     = StIdle;
      stop_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            if (source_framelen == 16'd0) begin
              cfg_err_d = 1'b1;
            end else begin
              ch_d       = source_channel;
              framelen_d = source_framelen;
              blanklen_d = source_blanklen;
              totalnum_d = source_totalnum;
              cutnum_d   = source_cutnum;
              headen_d   = source_headen;
              fs_d       = '0;
              cfg_err_d  = 1'b0;
              k_d        = '0;
              state_d    = source_headen ? StHead0 : StData;
            end
          end
        end
        StHead0: begin
          if (stop_edge) stop_pend_d = 1'b1;
          if (accept) state_d = StHead1;
        end
        StHead1: begin
          if (stop_edge) stop_pend_d = 1'b1;
          if (accept) begin
            state_d = StData;
            k_d     = '0;
          end
        end
        StData: begin
          if (stop_edge) stop_pend_d = 1'b1;
          if (accept) begin
            if (k_q == cur_len - 16'd1) begin
              fs_d = fs_q + 32'd1;
              // A stop edge landing on the eof beat still ends the run here.
              if ((totalnum_q != 32'd0 && fs_q + 32'd1 == totalnum_q) || stop_pend_q
                  || stop_edge) begin
                state_d     = StIdle;
                done_d      = 1'b1;
                stop_pend_d = 1'b0;
              end else if (blanklen_q == 16'd0) begin
                state_d = first_state;
                k_d     = '0;
              end else begin
                state_d = StGap;
                gap_d   = '0;
              end
            end else begin
              k_d = k_q + 16'd1;
            end
          end
        end
        StGap: begin
          if (stop_edge) begin
            state_d     = StIdle;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else if (gap_q == blanklen_q - 16'd1) begin
            state_d = first_state;
            k_d     = '0;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are precomputed from next state so the registered word lines up with it.
  always_comb begin
    next_len    = frame_len(framelen_d, cutnum_d, fs_d + 32'd1);
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_sof_d   = 1'b0;
    out_eof_d   = 1'b0;
    unique case (state_d)
      StHead0: begin
        out_valid_d = 1'b1;
        out_data_d  = {HEAD_SYNC, ch_d, 8'h00};
        out_sof_d   = 1'b1;
      end
      StHead1: begin
        out_valid_d = 1'b1;
        out_data_d  = fs_d;
      end
      StData: begin
        out_valid_d = 1'b1;
        out_data_d  = {ch_d, 8'h00, k_d};
        out_sof_d   = ~headen_d & (k_d == 16'd0);
        out_eof_d   = (k_d == next_len - 16'd1);
      end
      default: ;
    endcase
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_sof     = out_sof_q;
  assign out_eof     = out_eof_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign frames_sent = fs_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: doc/source_frame_gen.md
# source_frame_gen

Test-pattern frame generator that consumes the `source_*` control registers written by the CPU and produces a framed 32-bit word stream with valid/ready handshake toward the source FIFO/packetiser. Each frame carries an optional 2-word header, a payload of `framelen` words and an idle gap of `blanklen` cycles. Frame count, abort-on-stop, FIFO-clear abort and single-frame truncation (error injection) are supported.

## Interface
- `HEAD_SYNC`, 16'hEB90, sync pattern in header word 0
- `clk`  in  1  clock
- `pRST`  in  1  reset, asynchronous, active-high
- `source_channel`  in  8  channel ID placed in header and payload
- `source_framelen`  in  16  payload words per frame
- `source_blanklen`  in  16  idle cycles between frames
- `source_start_send`  in  1  CPU level; rising edge starts a run
- `source_stop_send`  in  1  CPU level; rising edge requests graceful stop
- `source_totalnum`  in  32  frames per run; 0 = unlimited
- `source_cutnum`  in  32  1-based frame index to truncate; 0 = disabled
- `source_headen`  in  1  1 = prepend 2 header words
- `source_clrfifo`  in  1  level; synchronous abort/clear while high
- `out_data`  out  32  stream word
- `out_valid`  out  1  word valid
- `out_ready`  in  1  downstream accepts when valid&ready
- `out_sof`  out  1  first word of frame (qualified by valid)
- `out_eof`  out  1  last word of frame (qualified by valid)
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse at run completion/stop
- `frames_sent`  out  32  frames whose eof was accepted in current run
- `cfg_err`  out  1  sticky: start rejected due to framelen=0

## Operation
- Start/stop edges: registered `start_d`, `stop_d` (reset 0); edge = in & !in_d.
- Start edge in IDLE with framelen!=0: latch channel, framelen, blanklen, totalnum, cutnum, headen; clear frames_sent, cfg_err; go HEAD0 (headen=1) else DATA. Start with framelen=0: set cfg_err, stay IDLE. Start edge while busy ignored. Mid-run register changes ignored.
- States: IDLE, HEAD0, HEAD1, DATA, GAP. Transitions advance only on accepted word (valid&ready), except GAP.
- HEAD0 word = {HEAD_SYNC, channel, 8'h00}; HEAD1 word = frame sequence number (frames_sent value, 0-based). sof on first word of frame (HEAD0, or DATA word 0 if headen=0).
- DATA word k = {channel, k[23:0]}, k = 0..len-1; len = framelen, or max(1, framelen>>1) when frame index (frames_sent+1) == cutnum. eof on word len-1.
- On eof accept: frames_sent++. If totalnum!=0 and new count == totalnum, or stop pending: go IDLE, pulse done. Else blanklen==0: next frame start state directly; else GAP.
- GAP: out_valid=0 for exactly blanklen cycles, then next frame start state.
- Stop edge: sets stop pending; in GAP go IDLE immediately with done; in HEAD/DATA finish current frame. Ignored in IDLE. Start and stop edges same cycle in IDLE: start taken, stop ignored.
- source_clrfifo=1: state forced IDLE, out_valid=0, stop pending cleared, no done pulse; frames_sent holds. Takes priority over all events; start edges while high ignored.
- k and GAP counters 16-bit; frames_sent wraps at 2^32 (unlimited mode).

## Timing
- Reset: out_data=0, out_valid=0, out_sof=0, out_eof=0, busy=0, done=0, frames_sent=0, cfg_err=0, state IDLE, all latched config 0.
- Start edge sampled cycle N -> out_valid=1 with first word in N+1.
- Output registered; out_data/sof/eof stable while valid&!ready.
- Back-to-back: with blanklen=0, next sof word valid the cycle after eof accept. With blanklen=B, B cycles of valid=0, sof valid at cycle eof_accept+B+1.
- done asserted the cycle after final eof accept (same cycle busy falls).
- pRST mid-frame: immediate return to reset values.

## Test plan
- headen=1, framelen=4, blanklen=2, totalnum=2, channel=8'h05, ready=1 -> words EB900500, 0, 05000000..05000003 (eof), 2 idle, EB900500, 1, 4 payload; done, frames_sent=2.
- headen=0, framelen=8, cutnum=2, totalnum=3 -> frame lengths 8,4,8; framelen=1 with cutnum=1 -> 1 word.
- ready toggled 1/0 each cycle, framelen=5 -> data held during stalls, exactly 5 accepted words, sof/eof correct.
- totalnum=0, stop edge during DATA word 2 of framelen=6 -> frame completes, IDLE, done; stop during GAP -> IDLE next cycle.
- source_clrfifo pulsed mid-frame -> valid drops next cycle, no done, busy=0; start with framelen=0 -> cfg_err=1, busy stays 0.
- pRST asserted mid-DATA -> all outputs at reset values asynchronously.
